mmio_uart_tx: RTL and testbench
===============================

# mmio_uart_tx

Memory-mapped UART transmitter on the CPU data-memory write bus, alongside the data memory. Consumes the processor's `memwrite`/`dataadr`/`writedata` store stream: a store to the TX data address enqueues one byte into an internal FIFO, and a serial engine drains the FIFO as 8N1 frames on `tx`. It gives test programs a visible output channel without disturbing data-memory traffic.

## Interface
- `CLKS_PER_BIT`, 868: clock cycles per serial bit (100 MHz / 115200); legal range 2–65535.
- `FIFO_DEPTH`, 16: byte FIFO entries; power of two, 2–256.
- `TX_ADDR`, 32'h0000_0FF0: byte address of the TX data register; status register is at `TX_ADDR+4`.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `memwrite`  in  1  store strobe from the CPU, one cycle per store.
- `dataadr`  in  32  store address.
- `writedata`  in  32  store data; bits [7:0] are transmitted.
- `tx`  out  1  serial line, idle high.
- `busy`  out  1  high while the FIFO is non-empty or a frame is in progress.
- `status`  out  32  {16'b0, drop_cnt[7:0], fifo_full, fifo_empty, busy, count[4:0]}; combinational from registers.

## Operation
- Push: `memwrite && dataadr == TX_ADDR` with the FIFO not full (pre-edge state) writes `writedata[7:0]` at the edge. Stores to any other address, including `TX_ADDR+4`, are ignored.
- Overflow: a push while full is discarded, and `drop_cnt` increments, saturating at 255. A pop in the same cycle does not rescue the push.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START when the FIFO is non-empty. The pop happens on the same edge and the byte is latched into the shift register.
  - START: `tx`=0 for CLKS_PER_BIT cycles -> DATA.
  - DATA: 8 bits LSB first, CLKS_PER_BIT cycles each. A 3-bit index selects the bit. After bit 7 -> STOP.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles. Then -> START with a pop if the FIFO is non-empty, else -> IDLE. This gives back-to-back frames with no idle gap.
- The baud counter reloads to 0 on every state/bit change and counts to CLKS_PER_BIT-1.
- `tx` is registered; IDLE drives 1.
- Simultaneous push and pop with the FIFO neither full nor empty: both happen and `count` is unchanged.

## Timing
- Reset values: `tx`=1, `busy`=0, FIFO empty, `count`=0, `drop_cnt`=0, state IDLE. `status` reads 32'h0000_0040.
- Reset mid-frame aborts immediately: `tx` returns high asynchronously and queued bytes are lost.
- Latency: a store accepted at edge N into an empty, idle block produces state START at edge N+1. `tx` falls after edge N+1.
- One frame lasts exactly 10·CLKS_PER_BIT cycles.
- `busy` rises the cycle after an accepted push (count becomes non-zero). It falls the cycle after the final STOP bit completes with the FIFO empty.
- One store per cycle is sustained; there is no backpressure to the CPU.

## Structure
- Shared package `mmio_pkg`: TX/status address constants, the FSM state enum (`uart_state_t`), and the status bit-position localparams.
- Sub-module `sync_fifo` (parameterised width/depth, push/pop/full/empty/count). The top level holds address decode, the drop counter, and the TX FSM.

## Test plan
- Reset, then idle 100 cycles (CLKS_PER_BIT=4) -> `tx`=1 throughout, `status`=32'h40.
- Store 8'hA5 to 0xFF0 -> `tx` low from cycle N+1. Sampled mid-bit: 0,1,0,1,0,0,1,0,1,1. Frame is 40 cycles; `busy` drops after the last stop bit.
- Stores to 0xFF4 and 0xFEC with 8'h55 -> no frame, `tx` stays 1, count 0.
- Burst of 18 stores 0x00–0x11 in consecutive cycles, depth 16 -> first 17 bytes transmitted (one popped during the burst). One dropped, `drop_cnt`=1. Frames are back-to-back with no gap.
- Assert `rst` during DATA bit 3 of byte 8'hFF -> `tx`=1 within the reset cycle. After release: FIFO empty, no resumed frame.
- Store while the final STOP bit ends with the FIFO empty -> the new byte starts its frame via IDLE one cycle later.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register addresses,
// TX engine state encoding and status-word bit positions.
package mmio_pkg;

  localparam logic [31:0] TX_DATA_ADDR   = 32'h0000_0FF0;
  localparam logic [31:0] TX_STATUS_ADDR = TX_DATA_ADDR + 32'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int STAT_COUNT_LSB = 0;
  localparam int STAT_COUNT_W   = 5;
  localparam int STAT_BUSY_BIT  = 5;
  localparam int STAT_EMPTY_BIT = 6;
  localparam int STAT_FULL_BIT  = 7;
  localparam int STAT_DROP_LSB  = 8;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through read data and an occupancy count.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; entries are only read after being written, and this keeps it RAM-mappable.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Store-bus snooping UART transmitter: stores to TX_ADDR queue a byte, and the
// TX engine drains the queue as back-to-back 8N1 frames.
module mmio_uart_tx
  import mmio_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 868,
  parameter int          FIFO_DEPTH   = 16,
  parameter logic [31:0] TX_ADDR      = TX_DATA_ADDR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memwrite,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  output logic        tx,
  output logic        busy,
  output logic [31:0] status
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  logic          tx_hit;
  logic          push;
  logic          pop;
  logic [7:0]    fifo_rdata;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [7:0]    drop_cnt;

  uart_state_t   state, state_next;
  logic [BW-1:0] baud_cnt, baud_next;
  logic [2:0]    bit_idx, bit_next;
  logic [7:0]    shift, shift_next;
  logic          tx_next;
  logic          baud_done;

  // Only the low byte of a store is transmitted.
  logic unused_wdata_hi;
  assign unused_wdata_hi = ^writedata[31:8];

  assign tx_hit = memwrite && (dataadr == TX_ADDR);
  assign push   = tx_hit && !fifo_full;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (writedata[7:0]),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Full is judged on the pre-edge state, so a same-cycle pop never rescues a push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     drop_cnt <= '0;
    else if (tx_hit && fifo_full) drop_cnt <= sat_inc8(drop_cnt);
  end

  assign baud_done = (baud_cnt == BAUD_LAST);

  // NOTE: every output of this block gets a default first, so no latch can be inferred.
  always_comb begin
    state_next = state;
    baud_next  = baud_cnt;
    bit_next   = bit_idx;
    shift_next = shift;
    pop        = 1'b0;

    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          state_next = START;
          pop        = 1'b1;
          shift_next = fifo_rdata;
          baud_next  = '0;
        end
      end
      START: begin
        if (baud_done) begin
          state_next = DATA;
          bit_next   = '0;
          baud_next  = '0;
        end else begin
          baud_next = baud_cnt + BW'(1);
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_next = '0;
          if (bit_idx == 3'd7) state_next = STOP;
          else                 bit_next   = bit_idx + 3'd1;
        end else begin
          baud_next = baud_cnt + BW'(1);
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_next = '0;
          // Chain straight into the next start bit to avoid an idle gap.
          if (!fifo_empty) begin
            state_next = START;
            pop        = 1'b1;
            shift_next = fifo_rdata;
          end else begin
            state_next = IDLE;
          end
        end else begin
          baud_next = baud_cnt + BW'(1);
        end
      end
      default: state_next = IDLE;
    endcase

    // The line level is registered, so it is derived from where the FSM is going.
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[bit_next];
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_next;
      baud_cnt <= baud_next;
      bit_idx  <= bit_next;
      shift    <= shift_next;
      tx       <= tx_next;
    end
  end

  assign busy = !fifo_empty || (state != IDLE);

  always_comb begin
    status = '0;
    status[STAT_COUNT_LSB +: STAT_COUNT_W] = STAT_COUNT_W'(fifo_count);
    status[STAT_BUSY_BIT]                  = busy;
    status[STAT_EMPTY_BIT]                 = fifo_empty;
    status[STAT_FULL_BIT]                  = fifo_full;
    status[STAT_DROP_LSB +: 8]             = drop_cnt;
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx: a queue-and-frame-timer model predicts popped
// bytes and their start cycles; a serial monitor decodes tx and compares.
module tb_mmio_uart_tx;

  localparam int          CPB     = 4;
  localparam int          DEPTH   = 16;
  localparam logic [31:0] TX_ADDR = 32'h0000_0FF0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        memwrite = 1'b0;
  logic [31:0] dataadr = '0;
  logic [31:0] writedata = '0;
  logic        tx;
  logic        busy;
  logic [31:0] status;

  mmio_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH),
    .TX_ADDR      (TX_ADDR)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .memwrite  (memwrite),
    .dataadr   (dataadr),
    .writedata (writedata),
    .tx        (tx),
    .busy      (busy),
    .status    (status)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] mq[$];
  int         frame_left = 0;
  int         m_drops = 0;
  int         cycle = 0;
  int         n_cmp = 0;
  int         n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Reference model: a byte queue plus a frame timer; a pop may happen when the
  // engine is idle or its current frame ends on this edge.
  initial begin
    forever begin
      @(posedge clk);
      cycle++;
      if (rst) begin
        mq.delete();
        exp_q.delete();
        frame_left = 0;
        m_drops = 0;
      end else begin
        bit pre_full, pre_empty, can_pop;
        pre_full  = (mq.size() == DEPTH);
        pre_empty = (mq.size() == 0);
        can_pop   = (frame_left <= 1) && !pre_empty;
        if (frame_left > 0) frame_left--;
        if (can_pop) begin
          exp_t e;
          e.data = mq.pop_front();
          e.cyc  = cycle;
          exp_q.push_back(e);
          frame_left = 10 * CPB;
        end
        if (memwrite && dataadr == TX_ADDR) begin
          if (pre_full) m_drops = (m_drops == 255) ? 255 : m_drops + 1;
          else          mq.push_back(writedata[7:0]);
        end
      end
    end
  end

  // Per-cycle status and idle-line checks.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        logic [31:0] s;
        logic        m_busy;
        m_busy = (mq.size() != 0) || (frame_left > 0);
        s = {16'h0, 8'(m_drops), (mq.size() == DEPTH), (mq.size() == 0), m_busy, 5'(mq.size())};
        check("status", status, s);
        if (frame_left == 0) check("tx_idle", tx, 1);
      end
    end
  end

  // Serial monitor: decode each frame mid-bit and compare with the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && tx == 1'b0) begin
        exp_t       e;
        logic [9:0] bits;
        bit         have_exp;
        bit         aborted;
        have_exp = (exp_q.size() != 0);
        if (have_exp) begin
          e = exp_q.pop_front();
          check("start_cycle", cycle, e.cyc);
        end else begin
          check("unexpected_frame", 1, 0);
        end
        aborted = 1'b0;
        bits = '1;
        for (int j = 0; j < 10 * CPB; j++) begin
          if (j > 0) @(negedge clk);
          if (rst) begin
            aborted = 1'b1;
            break;
          end
          if (j % CPB == CPB / 2) bits[j / CPB] = tx;
        end
        if (!aborted && have_exp) check("frame_bits", bits, {1'b1, e.data, 1'b0});
      end
    end
  end

  task automatic store(input logic [31:0] addr, input logic [7:0] data);
    @(negedge clk);
    memwrite  = 1'b1;
    dataadr   = addr;
    writedata = {$urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), data};
    @(negedge clk);
    memwrite  = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int limit);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < limit);
    check(name, busy, 0);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    #1 rst = 1'b1;
    repeat (cycles) @(negedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    do_reset(3);
    @(negedge clk);
    check("reset_status", status, 32'h0000_0040);
    check("reset_tx", tx, 1);
    check("reset_busy", busy, 0);
    repeat (100) @(negedge clk);

    store(TX_ADDR, 8'hA5);
    wait_idle("a5_drain", 200);

    store(TX_ADDR + 32'd4, 8'h55);
    store(TX_ADDR - 32'd4, 8'h55);
    repeat (60) @(negedge clk);
    check("other_addr_count", status[4:0], 0);

    // Eighteen consecutive stores into a depth-16 queue: one pops, one drops.
    @(negedge clk);
    for (int i = 0; i < 18; i++) begin
      memwrite  = 1'b1;
      dataadr   = TX_ADDR;
      writedata = 32'(i);
      @(negedge clk);
    end
    memwrite = 1'b0;
    wait_idle("burst_drain", 1200);
    check("burst_drop_cnt", status[15:8], 1);

    // Reset while bit 3 of 0xFF is on the line.
    store(TX_ADDR, 8'hFF);
    repeat (18) @(posedge clk);
    #2 rst = 1'b1;
    #1 check("reset_mid_frame_tx", tx, 1);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_reset_status", status, 32'h0000_0040);
    repeat (50) @(negedge clk);

    // Second store lands on the edge where the first frame's stop bit ends.
    store(TX_ADDR, 8'h3C);
    repeat (39) @(negedge clk);
    store(TX_ADDR, 8'hC3);
    wait_idle("stop_edge_drain", 200);

    // Randomised traffic with occasional full-rate bursts.
    for (int c = 0; c < 1500; c++) begin
      int r;
      @(negedge clk);
      r = $urandom_range(0, 99);
      memwrite = 1'b0;
      if ((c % 400) >= 380 || r < 6) begin
        memwrite  = 1'b1;
        dataadr   = TX_ADDR;
        writedata = $urandom();
      end else if (r < 9) begin
        memwrite  = 1'b1;
        dataadr   = (r == 6) ? TX_ADDR + 32'd4 : {$urandom_range(0, 1023), 2'b00};
        writedata = $urandom();
      end
    end
    @(negedge clk);
    memwrite = 1'b0;
    wait_idle("random_drain", 20 * DEPTH * CPB * 10);
    repeat (5) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
